// File: rtl/conv_pkg.sv
// Shared types and defaults for the 3x3 convolution stage.
// Pixel/weight/accumulator widths and the identity kernel live here.
package conv_pkg;

  localparam int DEF_IMG_W = 8;
  localparam int DEF_IMG_H = 8;
  localparam int DEF_GROUP = 4;

  typedef logic [7:0]        pixel_t;
  typedef logic signed [7:0] weight_t;
  typedef weight_t [8:0]     kernel_t;
  typedef logic signed [20:0] acc_t;

  // Only the centre tap (index 4) is 1.
  localparam kernel_t IDENT_KERNEL = 72'h00_0000_0001_0000_0000;

  function automatic logic signed [16:0] mul_px(pixel_t p, weight_t w);
    return 17'(signed'({1'b0, p})) * 17'(w);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One-row delay line: returns the pixel written DEPTH accepts ago, 0 cycles.
// Advances only on i_en; no backpressure.
module line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_ptr;

  assign o_dat = r_mem[r_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
    end
  end

  // Contents are never read before being rewritten in the current frame.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[r_ptr] <= i_dat;
    end
  end

endmodule

// File: rtl/conv3x3_engine.sv
// Streaming 3x3 convolution with ReLU, shift and saturation; 2-cycle latency
// from the accepting edge. No backpressure: bubbles only stop window/counters.
module conv3x3_engine
  import conv_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int SHIFT = 0,
  parameter int GROUP = DEF_GROUP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pixelIn,
  input  logic       pixelValid,
  input  logic       wLoad,
  input  logic [3:0] wIdx,
  input  logic [7:0] wData,
  output logic [7:0] convResult,
  output logic       convValid,
  output logic       En
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = (GROUP > 1) ? $clog2(GROUP) : 1;

  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic [GW-1:0]  r_grp;
  kernel_t        r_w;
  pixel_t [8:0]   r_win;
  logic           r_s1_vld;
  logic           r_s2_vld;
  acc_t           r_sum;

  logic [7:0]     w_lb0;
  logic [7:0]     w_lb1;
  logic           w_win_vld;
  acc_t           w_sum;
  acc_t           w_relu;
  acc_t           w_shr;
  logic [7:0]     w_sat;

  line_buffer #(.DEPTH(IMG_W), .WIDTH(8)) u_lb0 (
    .clk(clk), .rst_n(rst_n), .i_en(pixelValid), .i_dat(pixelIn), .o_dat(w_lb0)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(8)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .i_en(pixelValid), .i_dat(w_lb0), .o_dat(w_lb1)
  );

  assign w_win_vld = pixelValid && (r_row >= RW'(2)) && (r_col >= CW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (pixelValid) begin
      if (r_col == CW'(IMG_W - 1)) begin
        r_col <= '0;
        r_row <= (r_row == RW'(IMG_H - 1)) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w <= IDENT_KERNEL;
    end else if (wLoad && (wIdx <= 4'd8)) begin
      r_w[wIdx] <= wData;
    end
  end

  // Index k = 3*row + col inside the window; column 2 is the newest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win    <= '0;
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_sum    <= '0;
    end else begin
      r_s1_vld <= w_win_vld;
      r_s2_vld <= r_s1_vld;
      if (pixelValid) begin
        r_win <= {pixelIn, r_win[8], r_win[7],
                  w_lb0,   r_win[5], r_win[4],
                  w_lb1,   r_win[2], r_win[1]};
      end
      if (r_s1_vld) begin
        r_sum <= w_sum;
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (logic [3:0] k = 4'd0; k < 4'd9; k++) begin
      w_sum = w_sum + acc_t'(mul_px(r_win[k], r_w[k]));
    end
  end

  always_comb begin
    w_relu = r_sum[20] ? '0 : r_sum;
    w_shr  = w_relu >>> SHIFT;
    w_sat  = (w_shr > acc_t'(255)) ? 8'hFF : w_shr[7:0];
  end

  // GROUP divides the per-frame result count, so r_grp is 0 at every frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      convResult <= '0;
      convValid  <= 1'b0;
      En         <= 1'b0;
      r_grp      <= '0;
    end else begin
      convValid <= r_s2_vld;
      En        <= 1'b0;
      if (r_s2_vld) begin
        convResult <= w_sat;
        if (r_grp == GW'(GROUP - 1)) begin
          En    <= 1'b1;
          r_grp <= '0;
        end else begin
          r_grp <= r_grp + GW'(1);
        end
      end
    end
  end

endmodule
